// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing one valid/ready bus to the memory/MMIO
// decoder. The winning request is latched at grant so the slave sees a stable
// transfer. A stalled slave is forced to complete after TIMEOUT busy cycles
// with read data 0, which the CPU decodes as an illegal instruction.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  // master 0 (CPU)
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  // master 1 (DMA / debug)
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  // slave side (decoder)
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  // status
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [7:0]  err_count
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  logic                 last_m1;   // 1: master 1 owned the bus most recently
  logic [CNT_WIDTH-1:0] cnt;

  logic pick_m1;
  logic any_req;
  logic cnt_expired;
  logic done;

  // Arbitration choice and completion decode for the current cycle.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    any_req     = m0_valid | m1_valid;
    pick_m1     = m1_valid & (~m0_valid | ~last_m1);
    cnt_expired = (cnt == CNT_LAST);
    // Reset aborts a transfer in flight: no ready may escape in that cycle.
    done        = (state == BUSY) & (s_ready | cnt_expired) & ~reset;
    timeout_err = done & ~s_ready;
    m0_ready    = done & grant[0];
    m1_ready    = done & grant[1];
    // Read data passes through on a real completion, is 0 on timeout or when idle.
    m0_rdata    = (m0_ready & s_ready) ? s_rdata : 32'h0;
    m1_rdata    = (m1_ready & s_ready) ? s_rdata : 32'h0;
  end

  // Arbiter FSM: grant and latch a request in IDLE, wait for completion in BUSY.
  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      cnt       <= '0;
      s_valid   <= 1'b0;
      s_addr    <= 32'h0;
      s_wdata   <= 32'h0;
      s_wstrb   <= 4'h0;
      grant     <= 2'b00;
      err_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= BUSY;
            s_valid <= 1'b1;
            cnt     <= '0;
            last_m1 <= pick_m1;
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            s_addr  <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            s_wstrb <= pick_m1 ? m1_wstrb : m0_wstrb;
          end
        end
        BUSY: begin
          if (s_ready || cnt_expired) begin
            state   <= IDLE;
            s_valid <= 1'b0;
            grant   <= 2'b00;
            cnt     <= '0;
            if (!s_ready && err_count != 8'hff)
              err_count <= err_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=8). Inputs change on the falling
// edge; outputs are checked on the falling edge, #1 after any input change.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, s_valid, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TIMEOUT(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_rdata = 0;
    tick(); tick(); #1;
    if ({s_valid, grant, m0_ready, m1_ready, timeout_err} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000", {s_valid, grant, m0_ready, m1_ready, timeout_err});
      n_err++;
    end
    n_cmp++;
    if ({s_addr, s_wdata, s_wstrb, err_count, m0_rdata, m1_rdata} !== '0) begin
      $display("FAIL reset_data: s_addr=%h s_wdata=%h s_wstrb=%h err_count=%h expected all 0",
               s_addr, s_wdata, s_wstrb, err_count);
      n_err++;
    end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    m0_valid = 1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0;
    tick(); #1;  // BUSY cycle 1
    if (s_addr !== 32'h4000_0010 || s_valid !== 1'b1 || grant !== 2'b01) begin
      $display("FAIL read_grant: s_addr=%h s_valid=%b grant=%b expected 40000010 1 01", s_addr, s_valid, grant);
      n_err++;
    end
    n_cmp++;
    if (m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      $display("FAIL read_early_ready: m0_ready=%b m0_rdata=%h expected 0 0", m0_ready, m0_rdata);
      n_err++;
    end
    n_cmp++;
    tick(); tick();  // BUSY cycle 3
    s_ready = 1; s_rdata = 32'hDEAD_BEEF; #1;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_ready !== 1'b0) begin
      $display("FAIL read_ready: m0_ready=%b m0_rdata=%h m1_ready=%b expected 1 deadbeef 0",
               m0_ready, m0_rdata, m1_ready);
      n_err++;
    end
    n_cmp++;
    tick();
    m0_valid = 0; s_ready = 0; s_rdata = 0; #1;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0) begin
      $display("FAIL read_after: grant=%b s_valid=%b m0_ready=%b expected 00 0 0", grant, s_valid, m0_ready);
      n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (grant !== 2'b00) begin
      $display("FAIL read_no_regrant: grant=%b expected 00", grant);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    int r0 = 0;
    int r1 = 0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    reset = 1; tick(); reset = 0;
    m0_valid = 1; m0_addr = 32'h0000_1000;
    m1_valid = 1; m1_addr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (grant !== exp_g[i]) begin
        $display("FAIL rr_grant[%0d]: grant=%b expected %b", i, grant, exp_g[i]);
        n_err++;
      end
      n_cmp++;
      s_ready = 1; s_rdata = 32'h100 + i; #1;
      if ({m1_ready, m0_ready} !== exp_g[i]) begin
        $display("FAIL rr_ready[%0d]: {m1,m0}_ready=%b expected %b", i, {m1_ready, m0_ready}, exp_g[i]);
        n_err++;
      end
      n_cmp++;
      if (m0_ready) r0++;
      if (m1_ready) r1++;
      tick();
      s_ready = 0; #1;
      if (grant !== 2'b00) begin
        $display("FAIL rr_idle[%0d]: grant=%b expected 00", i, grant);
        n_err++;
      end
      n_cmp++;
    end
    if (r0 !== 2 || r1 !== 2) begin
      $display("FAIL rr_counts: m0 readies=%0d m1 readies=%0d expected 2 2", r0, r1);
      n_err++;
    end
    n_cmp++;
    m0_valid = 0; m1_valid = 0;
    tick();
  endtask

  task automatic test_latched_write();
    m1_valid = 1; m1_addr = 32'hC300_0000; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hf;
    tick(); #1;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_addr !== 32'hC300_0000 || s_wdata !== 32'h1234_5678 || s_wstrb !== 4'hf || grant !== 2'b10) begin
        $display("FAIL wr_hold[%0d]: s_addr=%h s_wdata=%h s_wstrb=%h grant=%b expected c3000000 12345678 f 10",
                 i, s_addr, s_wdata, s_wstrb, grant);
        n_err++;
      end
      n_cmp++;
      if (i < 2) tick();
    end
    s_ready = 1; s_rdata = 32'h0; #1;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
      $display("FAIL wr_ready: m1_ready=%b m0_ready=%b expected 1 0", m1_ready, m0_ready);
      n_err++;
    end
    n_cmp++;
    tick();
    m1_valid = 0; s_ready = 0;
    tick();
  endtask

  task automatic test_idle_sready();
    s_ready = 1; s_rdata = 32'hFFFF_0000; #1;
    if ({m0_ready, m1_ready, timeout_err} !== 3'b000) begin
      $display("FAIL idle_sready: ready/timeout=%b expected 000", {m0_ready, m1_ready, timeout_err});
      n_err++;
    end
    n_cmp++;
    tick(); #1;
    if (s_valid !== 1'b0 || grant !== 2'b00 || err_count !== 8'd0) begin
      $display("FAIL idle_state: s_valid=%b grant=%b err_count=%0d expected 0 00 0", s_valid, grant, err_count);
      n_err++;
    end
    n_cmp++;
    s_ready = 0; s_rdata = 0;
  endtask

  task automatic test_timeout();
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0; s_rdata = 32'hAAAA_5555;
    tick();  // BUSY cycle 1
    for (int c = 1; c < 8; c++) begin
      #1;
      if (m0_ready !== 1'b0 || timeout_err !== 1'b0) begin
        $display("FAIL to_early[%0d]: m0_ready=%b timeout_err=%b expected 0 0", c, m0_ready, timeout_err);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    #1;  // BUSY cycle 8
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0 || timeout_err !== 1'b1 || m1_ready !== 1'b0) begin
      $display("FAIL to_fire: m0_ready=%b m0_rdata=%h timeout_err=%b m1_ready=%b expected 1 0 1 0",
               m0_ready, m0_rdata, timeout_err, m1_ready);
      n_err++;
    end
    n_cmp++;
    tick();
    m0_valid = 0; #1;
    if (err_count !== 8'd1 || timeout_err !== 1'b0 || grant !== 2'b00) begin
      $display("FAIL to_after: err_count=%0d timeout_err=%b grant=%b expected 1 0 00", err_count, timeout_err, grant);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_ready_beats_timeout();
    m0_valid = 1;
    tick();
    repeat (7) tick();  // BUSY cycle 8
    s_ready = 1; s_rdata = 32'h5A5A_A5A5; #1;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h5A5A_A5A5 || timeout_err !== 1'b0) begin
      $display("FAIL tie_ready: m0_ready=%b m0_rdata=%h timeout_err=%b expected 1 5a5aa5a5 0",
               m0_ready, m0_rdata, timeout_err);
      n_err++;
    end
    n_cmp++;
    tick();
    m0_valid = 0; s_ready = 0; s_rdata = 32'hAAAA_5555; #1;
    if (err_count !== 8'd1) begin
      $display("FAIL tie_errcnt: err_count=%0d expected 1", err_count);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_err_saturate();
    for (int k = 0; k < 299; k++) begin
      m0_valid = 1;
      repeat (9) tick();
      m0_valid = 0;
    end
    #1;
    if (err_count !== 8'hff) begin
      $display("FAIL err_saturate: err_count=%h expected ff", err_count);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_in_busy();
    m0_valid = 1; m0_addr = 32'h0000_0200;
    tick(); #1;
    if (grant !== 2'b01) begin
      $display("FAIL rb_grant: grant=%b expected 01", grant);
      n_err++;
    end
    n_cmp++;
    tick();
    reset = 1; s_ready = 1; s_rdata = 32'h1111_2222; #1;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      $display("FAIL rb_no_ready: m0_ready=%b m1_ready=%b m0_rdata=%h expected 0 0 0", m0_ready, m1_ready, m0_rdata);
      n_err++;
    end
    n_cmp++;
    tick(); #1;
    if ({s_valid, grant, m0_ready, m1_ready, timeout_err} !== 6'b0 ||
        {s_addr, s_wdata, s_wstrb, err_count} !== '0) begin
      $display("FAIL rb_outputs: s_valid=%b grant=%b s_addr=%h err_count=%h expected all 0",
               s_valid, grant, s_addr, err_count);
      n_err++;
    end
    n_cmp++;
    reset = 0; s_ready = 0; m0_valid = 1; m1_valid = 1;
    tick(); #1;
    if (grant !== 2'b01) begin
      $display("FAIL rb_first_grant: grant=%b expected 01", grant);
      n_err++;
    end
    n_cmp++;
    s_ready = 1; #1;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      $display("FAIL rb_complete: m0_ready=%b m1_ready=%b expected 1 0", m0_ready, m1_ready);
      n_err++;
    end
    n_cmp++;
    tick();
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_latched_write();
    test_idle_sready();
    test_timeout();
    test_ready_beats_timeout();
    test_err_saturate();
    test_reset_in_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
